// File: rtl/dmem_dump_arbiter_pkg.sv
// Shared encodings for the data-memory dump arbiter: XLEN codes, dump FSM states
// and the word-size helpers.
package dmem_dump_arbiter_pkg;

  localparam int XLEN_32b = 1;
  localparam int XLEN_64b = 2;

  typedef enum logic [1:0] {
    DUMP_IDLE  = 2'd0,
    DUMP_ISSUE = 2'd1,
    DUMP_WAIT  = 2'd2,
    DUMP_HOLD  = 2'd3
  } dump_state_e;

  function automatic int word_bits(input int xlen);
    return 1 << (xlen + 4);
  endfunction

  function automatic int word_bytes(input int xlen);
    return word_bits(xlen) / 8;
  endfunction

endpackage

// File: rtl/dmem_dump_engine.sv
// Dump FSM: walks [start, end) one word at a time, stealing idle memory-port cycles
// and forcing a single grant once the core has blocked it STARVE_LIMIT times in a row.
module dmem_dump_engine
  import dmem_dump_arbiter_pkg::*;
#(
  parameter int W            = 32,
  parameter int B            = 4,
  parameter int STARVE_LIMIT = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_core_req,
  input  logic         i_dump_start,
  input  logic         i_dump_abort,
  input  logic [W-1:0] i_dump_start_addr,
  input  logic [W-1:0] i_dump_end_addr,
  input  logic [W-1:0] i_mem_rdata,
  input  logic         i_dump_ready,
  output logic         o_grant,
  output logic         o_forced,
  output logic [W-1:0] o_rd_addr,
  output logic         o_dump_busy,
  output logic         o_dump_done,
  output logic         o_dump_err,
  output logic         o_dump_valid,
  output logic [W-1:0] o_dump_addr,
  output logic [W-1:0] o_dump_data
);

  localparam int            AW    = $clog2(B);
  localparam int            CW    = $clog2(STARVE_LIMIT + 2);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  localparam logic [W-1:0]  STEP  = W'(B);

  dump_state_e   r_state;
  dump_state_e   w_state_nxt;
  logic [W-1:0]  r_cur_addr;
  logic [W-1:0]  r_end_addr;
  logic [CW-1:0] r_starve_cnt;
  logic          r_done;
  logic          r_err;
  logic          r_valid;
  logic [W-1:0]  r_addr;
  logic [W-1:0]  r_data;
  logic          w_grant;
  logic          w_forced;
  logic          w_range_ok;
  logic          w_last;
  logic          w_abort;

  assign w_range_ok = (i_dump_start_addr[AW-1:0] == '0) &&
                      (i_dump_end_addr[AW-1:0] == '0) &&
                      (i_dump_end_addr > i_dump_start_addr);
  assign w_last     = (r_cur_addr + STEP) >= r_end_addr;
  assign w_abort    = i_dump_abort && (r_state != DUMP_IDLE);

  // NOTE: every output of this block is given a default first, so no branch can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_forced    = 1'b0;
    case (r_state)
      DUMP_IDLE:  if (i_dump_start && w_range_ok) w_state_nxt = DUMP_ISSUE;
      DUMP_ISSUE: begin
        if (!i_core_req) begin
          w_grant     = 1'b1;
          w_state_nxt = DUMP_WAIT;
        end else if ((STARVE_LIMIT != 0) && (r_starve_cnt == LIMIT)) begin
          w_grant     = 1'b1;
          w_forced    = 1'b1;
          w_state_nxt = DUMP_WAIT;
        end
      end
      DUMP_WAIT:  w_state_nxt = DUMP_HOLD;
      DUMP_HOLD:  if (i_dump_ready) w_state_nxt = w_last ? DUMP_IDLE : DUMP_ISSUE;
      default:    w_state_nxt = DUMP_IDLE;
    endcase
    if (w_abort) begin
      w_state_nxt = DUMP_IDLE;
      w_grant     = 1'b0;
      w_forced    = 1'b0;
    end
  end

  // NOTE: state updates use <= so every branch below reads the pre-edge values of its peers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= DUMP_IDLE;
      r_cur_addr   <= '0;
      r_end_addr   <= '0;
      r_starve_cnt <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_valid      <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      if (w_abort) begin
        r_valid      <= 1'b0;
        r_starve_cnt <= '0;
      end else begin
        case (r_state)
          DUMP_IDLE: begin
            if (i_dump_start && w_range_ok) begin
              r_cur_addr <= i_dump_start_addr;
              r_end_addr <= i_dump_end_addr;
            end else if (i_dump_start) begin
              r_err <= 1'b1;
            end
          end
          DUMP_ISSUE: begin
            if (w_grant)                 r_starve_cnt <= '0;
            else if (STARVE_LIMIT != 0)  r_starve_cnt <= r_starve_cnt + 1'b1;
          end
          DUMP_WAIT: begin
            r_valid <= 1'b1;
            r_addr  <= r_cur_addr;
            r_data  <= i_mem_rdata;
          end
          DUMP_HOLD: begin
            if (i_dump_ready) begin
              r_valid <= 1'b0;
              if (w_last) r_done     <= 1'b1;
              else        r_cur_addr <= r_cur_addr + STEP;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_grant      = w_grant;
  assign o_forced     = w_forced;
  assign o_rd_addr    = r_cur_addr;
  assign o_dump_busy  = (r_state != DUMP_IDLE);
  assign o_dump_done  = r_done;
  assign o_dump_err   = r_err;
  assign o_dump_valid = r_valid;
  assign o_dump_addr  = r_addr;
  assign o_dump_data  = r_data;

endmodule

// File: rtl/dmem_dump_arbiter.sv
// Data-memory port mux between the MEM stage and the debug dump engine; the core
// wins every cycle except the single forced-grant cycle, where it is stalled.
module dmem_dump_arbiter
  import dmem_dump_arbiter_pkg::*;
#(
  parameter  int XLEN         = XLEN_32b,
  parameter  int STARVE_LIMIT = 16,
  localparam int W            = word_bits(XLEN),
  localparam int B            = word_bytes(XLEN)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_core_req,
  input  logic         i_core_we,
  input  logic [W-1:0] i_core_addr,
  input  logic [W-1:0] i_core_wdata,
  input  logic [B-1:0] i_core_wstrb,
  output logic         o_core_stall,
  output logic [W-1:0] o_core_rdata,
  output logic         o_mem_en,
  output logic         o_mem_we,
  output logic [W-1:0] o_mem_addr,
  output logic [W-1:0] o_mem_wdata,
  output logic [B-1:0] o_mem_wstrb,
  input  logic [W-1:0] i_mem_rdata,
  input  logic         i_dump_start,
  input  logic         i_dump_abort,
  input  logic [W-1:0] i_dump_start_addr,
  input  logic [W-1:0] i_dump_end_addr,
  output logic         o_dump_busy,
  output logic         o_dump_done,
  output logic         o_dump_err,
  output logic         o_dump_valid,
  output logic [W-1:0] o_dump_addr,
  output logic [W-1:0] o_dump_data,
  input  logic         i_dump_ready
);

  logic         w_grant;
  logic         w_forced;
  logic [W-1:0] w_rd_addr;

  dmem_dump_engine #(
    .W            (W),
    .B            (B),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_engine (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_core_req        (i_core_req),
    .i_dump_start      (i_dump_start),
    .i_dump_abort      (i_dump_abort),
    .i_dump_start_addr (i_dump_start_addr),
    .i_dump_end_addr   (i_dump_end_addr),
    .i_mem_rdata       (i_mem_rdata),
    .i_dump_ready      (i_dump_ready),
    .o_grant           (w_grant),
    .o_forced          (w_forced),
    .o_rd_addr         (w_rd_addr),
    .o_dump_busy       (o_dump_busy),
    .o_dump_done       (o_dump_done),
    .o_dump_err        (o_dump_err),
    .o_dump_valid      (o_dump_valid),
    .o_dump_addr       (o_dump_addr),
    .o_dump_data       (o_dump_data)
  );

  always_comb begin
    o_mem_en    = i_core_req;
    o_mem_we    = i_core_we;
    o_mem_addr  = i_core_addr;
    o_mem_wdata = i_core_wdata;
    o_mem_wstrb = i_core_wstrb;
    if (w_grant) begin
      o_mem_en    = 1'b1;
      o_mem_we    = 1'b0;
      o_mem_addr  = w_rd_addr;
      o_mem_wdata = '0;
      o_mem_wstrb = '0;
    end
  end

  // Read data is never retimed; after a dump read the core simply has nothing to consume.
  assign o_core_rdata = i_mem_rdata;
  assign o_core_stall = w_forced;

endmodule

// File: tb/tb_dmem_dump_arbiter.sv
// Scoreboard bench for dmem_dump_arbiter with a behavioural synchronous data memory.
module tb_dmem_dump_arbiter;
  import dmem_dump_arbiter_pkg::*;

  localparam int W     = 32;
  localparam int B     = 4;
  localparam int LIMIT = 4;

  typedef struct packed {
    logic [W-1:0] addr;
    logic [W-1:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_core_req = 1'b0, i_core_we = 1'b0;
  logic [W-1:0] i_core_addr = '0, i_core_wdata = '0;
  logic [B-1:0] i_core_wstrb = '0;
  logic         o_core_stall;
  logic [W-1:0] o_core_rdata;
  logic         o_mem_en, o_mem_we;
  logic [W-1:0] o_mem_addr, o_mem_wdata;
  logic [B-1:0] o_mem_wstrb;
  logic [W-1:0] i_mem_rdata;
  logic         i_dump_start = 1'b0, i_dump_abort = 1'b0, i_dump_ready = 1'b0;
  logic [W-1:0] i_dump_start_addr = '0, i_dump_end_addr = '0;
  logic         o_dump_busy, o_dump_done, o_dump_err, o_dump_valid;
  logic [W-1:0] o_dump_addr, o_dump_data;

  always #5 clk = ~clk;

  dmem_dump_arbiter #(.XLEN(XLEN_32b), .STARVE_LIMIT(LIMIT)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_core_req(i_core_req), .i_core_we(i_core_we), .i_core_addr(i_core_addr),
    .i_core_wdata(i_core_wdata), .i_core_wstrb(i_core_wstrb),
    .o_core_stall(o_core_stall), .o_core_rdata(o_core_rdata),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb), .i_mem_rdata(i_mem_rdata),
    .i_dump_start(i_dump_start), .i_dump_abort(i_dump_abort),
    .i_dump_start_addr(i_dump_start_addr), .i_dump_end_addr(i_dump_end_addr),
    .o_dump_busy(o_dump_busy), .o_dump_done(o_dump_done), .o_dump_err(o_dump_err),
    .o_dump_valid(o_dump_valid), .o_dump_addr(o_dump_addr), .o_dump_data(o_dump_data),
    .i_dump_ready(i_dump_ready)
  );

  // Behavioural memory: synchronous read, byte-strobed write, plus a bench preload port.
  logic [W-1:0] mem [0:63];
  logic         pre_we = 1'b0;
  logic [5:0]   pre_idx = '0;
  logic [W-1:0] pre_val = '0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_val;
    if (o_mem_en) begin
      if (o_mem_we) begin
        for (int b = 0; b < B; b++)
          if (o_mem_wstrb[b]) mem[o_mem_addr[7:2]][8*b +: 8] <= o_mem_wdata[8*b +: 8];
      end else begin
        i_mem_rdata <= mem[o_mem_addr[7:2]];
      end
    end
  end

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   err_cnt = 0;
  int   hs_cyc[$];
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake monitor: pops the scoreboard on every accepted word.
  always @(negedge clk) begin
    exp_t e;
    if (!i_rst && o_dump_valid && i_dump_ready && !i_dump_abort) begin
      hs_cyc.push_back(cyc);
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_word: got addr %h data %h, none expected", o_dump_addr, o_dump_data);
      end else begin
        e = sb.pop_front();
        if (o_dump_addr !== e.addr || o_dump_data !== e.data)
          $display("FAIL stream_word: got %h/%h want %h/%h", o_dump_addr, o_dump_data, e.addr, e.data);
        else n_pass++;
      end
    end
    if (o_dump_done) begin done_cnt++; done_cyc = cyc; end
    if (o_dump_err)  err_cnt++;
  end

  task automatic preload(input int idx, input logic [W-1:0] val);
    pre_idx = 6'(idx); pre_val = val; pre_we = 1'b1;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] d);
    exp_t e;
    e.addr = a; e.data = d;
    sb.push_back(e);
  endtask

  // Drives a one-cycle start; returns in the cycle after the sampling edge.
  task automatic start_dump(input logic [W-1:0] s, input logic [W-1:0] e, output int issue_cyc);
    i_dump_start_addr = s; i_dump_end_addr = e; i_dump_start = 1'b1;
    @(posedge clk); #1;
    i_dump_start = 1'b0;
    issue_cyc = cyc;
  endtask

  task automatic wait_done(input int bound);
    int d0 = done_cnt;
    int k = 0;
    while (done_cnt == d0 && k < bound) begin @(negedge clk); k++; end
    n_checks++;
    if (done_cnt == d0) $display("FAIL done_timeout: got no done pulse within %0d cycles", bound);
    else n_pass++;
  endtask

  task automatic wait_valid(input int bound);
    int k = 0;
    while (!o_dump_valid && k < bound) begin @(negedge clk); k++; end
    n_checks++;
    if (!o_dump_valid) $display("FAIL valid_timeout: got valid 0 after %0d cycles, want 1", bound);
    else n_pass++;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({o_dump_busy, o_dump_done, o_dump_err, o_dump_valid, o_core_stall, o_mem_en} !== 6'b0 ||
        o_dump_addr !== '0 || o_dump_data !== '0 || o_mem_addr !== '0)
      $display("FAIL reset_outputs: got busy%b done%b err%b valid%b stall%b en%b, want all 0",
               o_dump_busy, o_dump_done, o_dump_err, o_dump_valid, o_core_stall, o_mem_en);
    else n_pass++;
    @(posedge clk); #1;
    i_rst = 1'b0;
  endtask

  task automatic test_idle_dump();
    int ic;
    int d0;
    preload(0, 32'h11); preload(1, 32'h22); preload(2, 32'h33); preload(3, 32'h44);
    i_dump_ready = 1'b1;
    hs_cyc.delete();
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) push_exp(W'(4 * i), W'(32'h11 * (i + 1)));
    start_dump(32'h0, 32'h10, ic);
    @(negedge clk);
    n_checks++;
    if (o_mem_en !== 1'b1 || o_mem_we !== 1'b0 || o_mem_addr !== 32'h0)
      $display("FAIL first_read: got en%b we%b addr %h, want en1 we0 addr 0", o_mem_en, o_mem_we, o_mem_addr);
    else n_pass++;
    wait_done(60);
    n_checks++;
    if (o_dump_busy !== 1'b0) $display("FAIL busy_at_done: got %b want 0", o_dump_busy);
    else n_pass++;
    n_checks++;
    if (hs_cyc.size() != 4) $display("FAIL word_count: got %0d want 4", hs_cyc.size());
    else begin
      n_pass++;
      n_checks++;
      if (hs_cyc[0] != ic + 2) $display("FAIL first_valid_latency: got %0d want %0d", hs_cyc[0] - ic, 2);
      else n_pass++;
      for (int i = 1; i < 4; i++) begin
        n_checks++;
        if (hs_cyc[i] - hs_cyc[i-1] != 3) $display("FAIL word_spacing: got %0d want 3", hs_cyc[i] - hs_cyc[i-1]);
        else n_pass++;
      end
      n_checks++;
      if (done_cyc != hs_cyc[3] + 1) $display("FAIL done_timing: got %0d want %0d", done_cyc, hs_cyc[3] + 1);
      else n_pass++;
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_cnt - d0 != 1 || o_dump_busy !== 1'b0)
      $display("FAIL done_once: got %0d pulses busy %b, want 1 pulse busy 0", done_cnt - d0, o_dump_busy);
    else n_pass++;
  endtask

  task automatic test_bad_ranges();
    logic [W-1:0] sa [3] = '{32'h2, 32'h10, 32'h20};
    logic [W-1:0] ea [3] = '{32'h10, 32'h10, 32'h10};
    int ic;
    int e0;
    for (int i = 0; i < 3; i++) begin
      e0 = err_cnt;
      start_dump(sa[i], ea[i], ic);
      @(negedge clk);
      n_checks++;
      if (o_dump_err !== 1'b1 || o_dump_busy !== 1'b0 || o_mem_en !== 1'b0)
        $display("FAIL bad_range_%0d: got err%b busy%b en%b, want err1 busy0 en0", i, o_dump_err, o_dump_busy, o_mem_en);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (err_cnt - e0 != 1) $display("FAIL err_pulse_width_%0d: got %0d cycles want 1", i, err_cnt - e0);
      else n_pass++;
    end
  endtask

  task automatic test_starve();
    int ic;
    preload(8, 32'hA5A5_5A5A);
    push_exp(32'h20, 32'hA5A5_5A5A);
    i_dump_ready = 1'b1;
    i_core_req = 1'b1; i_core_we = 1'b0; i_core_addr = 32'h4;
    start_dump(32'h20, 32'h24, ic);
    for (int k = 0; k < LIMIT; k++) begin
      @(negedge clk);
      n_checks++;
      if (o_core_stall !== 1'b0 || o_mem_addr !== 32'h4)
        $display("FAIL core_owns_%0d: got stall%b addr %h, want stall0 addr 4", k, o_core_stall, o_mem_addr);
      else n_pass++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++;
    if (o_core_stall !== 1'b1 || o_mem_addr !== 32'h20 || o_mem_we !== 1'b0 || o_mem_en !== 1'b1)
      $display("FAIL forced_grant: got stall%b addr %h we%b, want stall1 addr 20 we0", o_core_stall, o_mem_addr, o_mem_we);
    else n_pass++;
    @(posedge clk); #1;
    i_core_we = 1'b1; i_core_addr = 32'h30; i_core_wdata = 32'hDEAD_BEEF; i_core_wstrb = 4'hF;
    @(negedge clk);
    n_checks++;
    if (o_core_stall !== 1'b0 || o_mem_en !== 1'b1 || o_mem_we !== 1'b1 || o_mem_addr !== 32'h30 || o_mem_wdata !== 32'hDEAD_BEEF)
      $display("FAIL store_after_stall: got stall%b en%b we%b addr %h data %h", o_core_stall, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata);
    else n_pass++;
    @(posedge clk); #1;
    i_core_req = 1'b0; i_core_we = 1'b0; i_core_wstrb = '0;
    wait_done(40);
    n_checks++;
    if (mem[12] !== 32'hDEAD_BEEF) $display("FAIL store_landed: got %h want deadbeef", mem[12]);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int ic;
    exp_t held;
    preload(16, 32'h1111_0001); preload(17, 32'h2222_0002);
    push_exp(32'h40, 32'h1111_0001); push_exp(32'h44, 32'h2222_0002);
    held = sb[0];
    i_dump_ready = 1'b0;
    start_dump(32'h40, 32'h48, ic);
    wait_valid(20);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++;
      if (o_dump_valid !== 1'b1 || o_dump_data !== held.data || o_dump_addr !== held.addr)
        $display("FAIL held_word_%0d: got v%b %h/%h want v1 %h/%h", k, o_dump_valid, o_dump_addr, o_dump_data, held.addr, held.data);
      else n_pass++;
      @(posedge clk); #1;
      if (k == 2) begin
        i_core_req = 1'b1; i_core_we = 1'b1; i_core_addr = 32'h40;
        i_core_wdata = 32'hFFFF_FFFF; i_core_wstrb = 4'hF;
      end
      if (k == 3) begin i_core_req = 1'b0; i_core_we = 1'b0; i_core_wstrb = '0; end
    end
    i_dump_ready = 1'b1;
    wait_done(40);
    n_checks++;
    if (mem[16] !== 32'hFFFF_FFFF) $display("FAIL hold_store_landed: got %h want ffffffff", mem[16]);
    else n_pass++;
  endtask

  task automatic test_abort();
    int ic;
    int d0;
    i_dump_ready = 1'b0;
    d0 = done_cnt;
    start_dump(32'h0, 32'h4, ic);
    wait_valid(20);
    n_checks++;
    if (o_dump_data !== 32'h11) $display("FAIL abort_held_data: got %h want 11", o_dump_data);
    else n_pass++;
    @(posedge clk); #1;
    i_dump_ready = 1'b1; i_dump_abort = 1'b1;
    @(posedge clk); #1;
    i_dump_ready = 1'b0; i_dump_abort = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_dump_busy !== 1'b0 || o_dump_valid !== 1'b0)
      $display("FAIL abort_idle: got busy%b valid%b want 0 0", o_dump_busy, o_dump_valid);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_cnt != d0) $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt - d0);
    else n_pass++;
    i_dump_ready = 1'b1;
    push_exp(32'h4, 32'h22);
    start_dump(32'h4, 32'h8, ic);
    wait_done(40);
  endtask

  task automatic test_reset_mid();
    int ic;
    int d0;
    i_dump_ready = 1'b1;
    i_core_req = 1'b1; i_core_we = 1'b0; i_core_addr = 32'h4;
    d0 = done_cnt;
    start_dump(32'h0, 32'h10, ic);
    @(negedge clk);
    n_checks++;
    if (o_dump_busy !== 1'b1) $display("FAIL busy_before_reset: got %b want 1", o_dump_busy);
    else n_pass++;
    @(posedge clk); #1;
    i_rst = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_dump_busy !== 1'b0 || o_dump_valid !== 1'b0 || done_cnt != d0)
      $display("FAIL reset_mid_issue: got busy%b valid%b done%0d want 0 0 0", o_dump_busy, o_dump_valid, done_cnt - d0);
    else n_pass++;
    i_core_req = 1'b0;
    push_exp(32'h8, 32'h33);
    @(posedge clk); #1;
    start_dump(32'h8, 32'hC, ic);
    wait_done(40);
  endtask

  task automatic test_back_to_back();
    int ic;
    int d0;
    i_dump_ready = 1'b1;
    d0 = done_cnt;
    push_exp(32'h0, 32'h11);
    start_dump(32'h0, 32'h4, ic);
    wait_valid(20);
    i_dump_start_addr = 32'h8; i_dump_end_addr = 32'hC; i_dump_start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (o_dump_done !== 1'b1 || o_dump_busy !== 1'b0)
      $display("FAIL b2b_done_cycle: got done%b busy%b want 1 0", o_dump_done, o_dump_busy);
    else n_pass++;
    push_exp(32'h8, 32'h33);
    @(posedge clk); #1;
    i_dump_start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_dump_busy !== 1'b1) $display("FAIL b2b_accepted: got busy %b want 1", o_dump_busy);
    else n_pass++;
    wait_done(40);
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_cnt - d0 != 2 || sb.size() != 0)
      $display("FAIL b2b_totals: got %0d dones %0d pending, want 2 dones 0 pending", done_cnt - d0, sb.size());
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_idle_dump();
    test_bad_ranges();
    test_starve();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    n_checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drained: got %0d pending want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
